// File: rtl/fp_add_normalize_round_if.sv
// fp_add_normalize_round_if: input beat, output result and valid/ready handshake of the FP normalize/round stage
interface fp_add_normalize_round_if;
    logic [27:0] Sum;
    logic [7:0]  ExponentBase;
    logic        ResultSign;
    logic        InValid;
    logic        InReady;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Result;
    logic        Overflow;
    logic        Underflow;
    logic        Inexact;
    modport master (
        output Sum, ExponentBase, ResultSign, InValid, OutReady,
        input  InReady, OutValid, Result, Overflow, Underflow, Inexact
    );
    modport slave (
        input  Sum, ExponentBase, ResultSign, InValid, OutReady,
        output InReady, OutValid, Result, Overflow, Underflow, Inexact
    );
endinterface

// File: rtl/fp_add_normalize_round.sv
// fp_add_normalize_round: normalizes the raw mantissa sum, rounds to nearest-even and packs a single-precision result
module fp_add_normalize_round (
    input  logic Clock,
    input  logic Reset,
    fp_add_normalize_round_if.slave bus
);
    logic              advance;
    logic [4:0]        lzc;
    logic signed [9:0] base_s;
    logic [26:0]       mant_d, mant_q;
    logic signed [9:0] exp_d, exp_q;
    logic              zero_d, zero_q, sign_q, v1_q;
    logic              g, s, up;
    logic [24:0]       rnd;
    logic signed [9:0] exp_r;
    logic [31:0]       result_d, result_q;
    logic              ovf_d, ovf_q, unf_d, unf_q, inx_d, inx_q, out_valid_q;

    assign advance      = !out_valid_q | bus.OutReady;
    assign bus.InReady  = advance;
    assign bus.OutValid = out_valid_q;
    assign bus.Result   = result_q;
    assign bus.Overflow = ovf_q;
    assign bus.Underflow = unf_q;
    assign bus.Inexact  = inx_q;
    assign base_s       = $signed({2'b00, bus.ExponentBase});

    // leading zeros of the carry-free sum: the highest set bit is the last to write
    always_comb begin
        lzc = 5'd0;
        for (int i = 0; i < 27; i++) if (bus.Sum[i]) lzc = 5'(26 - i);
    end

    // normalize: carry shifts right folding the lost bit into sticky, otherwise shift out leading zeros
    always_comb begin
        zero_d = bus.Sum == 28'd0;
        mant_d = bus.Sum[27] ? {bus.Sum[27:2], bus.Sum[1] | bus.Sum[0]} : bus.Sum[26:0] << lzc;
        exp_d  = bus.Sum[27] ? base_s + 10'sd1 : base_s - $signed({5'd0, lzc});
    end

    // round to nearest-even, renormalize a rounding carry, then saturate or flush the exponent
    always_comb begin
        g        = mant_q[2];
        s        = mant_q[1] | mant_q[0];
        up       = g & (s | mant_q[3]);
        rnd      = {1'b0, mant_q[26:3]} + {24'd0, up};
        exp_r    = exp_q + $signed({9'd0, rnd[24]});
        ovf_d    = !zero_q && exp_r >= 10'sd255;
        unf_d    = !zero_q && exp_r <= 10'sd0;
        inx_d    = !zero_q && (g | s | ovf_d | unf_d);
        result_d = zero_q ? 32'd0 :
                   ovf_d  ? {sign_q, 8'hFF, 23'd0} :
                   unf_d  ? {sign_q, 31'd0} :
                            {sign_q, exp_r[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
    end

    // stage 1 register: captures every input slot whenever the pipe advances
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mant_q <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            sign_q <= 1'b0;
            v1_q   <= 1'b0;
        end else if (advance) begin
            mant_q <= mant_d;
            exp_q  <= exp_d;
            zero_q <= zero_d;
            sign_q <= bus.ResultSign;
            v1_q   <= bus.InValid;
        end
    end

    // output register: bubbles clear OutValid but leave the last result and flags untouched
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else if (advance) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                result_q <= result_d;
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
                inx_q    <= inx_d;
            end
        end
    end
endmodule
